// File: rtl/instr_dispatch_fsm_if.sv
// rtl/instr_dispatch_fsm_if.sv - instruction fetch and execution-FSM handshake bundle
interface instr_dispatch_fsm_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 20
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_req;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_data;
    logic [3:0]         fsm_start;
    logic [3:0]         opcode;
    logic [5:0]         param1;
    logic [5:0]         param2;
    logic               fsm_done;

    modport master (
        output imem_addr, imem_req, fsm_start, opcode, param1, param2,
        input  imem_valid, imem_data, fsm_done
    );
    modport slave (
        input  imem_addr, imem_req, fsm_start, opcode, param1, param2,
        output imem_valid, imem_data, fsm_done
    );
endinterface

// File: rtl/instr_dispatch_fsm.sv
// rtl/instr_dispatch_fsm.sv - fetch/decode/issue sequencer for the execution FSMs
// Optional WAIT_DONE watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module instr_dispatch_fsm #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 20
`ifdef DISPATCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_run,
    instr_dispatch_fsm_if.master bus,
    output logic                 o_busy,
    output logic                 o_halted,
    output logic                 o_illegal_instr,
    output logic                 o_timeout_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE, S_ADVANCE, S_HALT
    } state_t;

    localparam logic [3:0] CLS_NOP   = 4'h0;
    localparam logic [3:0] CLS_LOAD  = 4'h1;
    localparam logic [3:0] CLS_ALU   = 4'h2;
    localparam logic [3:0] CLS_STORE = 4'h3;
    localparam logic [3:0] CLS_HALT  = 4'hF;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_word;
    logic [3:0]         r_start, r_opcode;
    logic [5:0]         r_param1, r_param2;
    logic               r_req, r_busy, r_halted, r_illegal;
    logic [3:0]         w_class, w_start_nxt;
    logic               w_capture, w_latch, w_pc_inc, w_illegal_nxt;

    assign w_class = r_word[INSTR_W-1 -: 4];

`ifdef DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout, w_timeout_nxt, w_wait_expired;

    // Terminal WAIT_DONE cycle is the TIMEOUT_CYCLES-th one since entry.
    assign w_wait_expired = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_latch       = 1'b0;
        w_pc_inc      = 1'b0;
        w_illegal_nxt = 1'b0;
        w_start_nxt   = 4'h0;
`ifdef DISPATCH_TIMEOUT_EN
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE:   if (i_run) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (bus.imem_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_latch = 1'b1;
                case (w_class)
                    CLS_LOAD, CLS_ALU, CLS_STORE: begin
                        w_start_nxt = w_class;
                        w_state_nxt = S_ISSUE;
                    end
                    CLS_NOP:  w_state_nxt = S_ADVANCE;
                    CLS_HALT: w_state_nxt = S_HALT;
                    default: begin
                        w_illegal_nxt = 1'b1;
                        w_state_nxt   = S_ADVANCE;
                    end
                endcase
            end
            S_ISSUE:  w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.fsm_done) begin
                    w_state_nxt = S_ADVANCE;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (w_wait_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_ADVANCE;
                end
`endif
            end
            S_ADVANCE: begin
                w_pc_inc    = 1'b1;
                w_state_nxt = i_run ? S_FETCH : S_IDLE;
            end
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_start   <= 4'h0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= (w_state_nxt == S_FETCH);
            r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HALT);
            r_halted  <= (w_state_nxt == S_HALT);
            r_start   <= w_start_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc     <= '0;
            r_word   <= '0;
            r_opcode <= 4'h0;
            r_param1 <= 6'h0;
            r_param2 <= 6'h0;
        end else begin
            if (w_capture) r_word <= bus.imem_data;
            if (w_latch) begin
                r_opcode <= r_word[INSTR_W-5 -: 4];
                r_param1 <= r_word[11:6];
                r_param2 <= r_word[5:0];
            end
            if (w_pc_inc) r_pc <= r_pc + ADDR_W'(1);
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
            if (r_state == S_ISSUE) r_wait_cnt <= '0;
            else if (r_state == S_WAIT_DONE) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end
    assign o_timeout_err = r_timeout;
`else
    assign o_timeout_err = 1'b0;
`endif

    assign bus.imem_addr   = r_pc;
    assign bus.imem_req    = r_req;
    assign bus.fsm_start   = r_start;
    assign bus.opcode      = r_opcode;
    assign bus.param1      = r_param1;
    assign bus.param2      = r_param2;
    assign o_busy          = r_busy;
    assign o_halted        = r_halted;
    assign o_illegal_instr = r_illegal;
endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// tb/tb_instr_dispatch_fsm.sv - randomized self-checking bench for instr_dispatch_fsm
module tb_instr_dispatch_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic busy, halted, illegal, tmo;
    int n_tests = 0;
    int n_fail = 0;
    logic [19:0] mem [256];

    always #5 clk = ~clk;

    instr_dispatch_fsm_if #(.ADDR_W(8), .INSTR_W(20)) bus ();

    instr_dispatch_fsm #(.ADDR_W(8), .INSTR_W(20)) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_run           (run),
        .bus             (bus),
        .o_busy          (busy),
        .o_halted        (halted),
        .o_illegal_instr (illegal),
        .o_timeout_err   (tmo)
    );

    function automatic bit is_exec(input logic [3:0] c);
        return (c == 4'h1) || (c == 4'h2) || (c == 4'h3);
    endfunction

    function automatic bit is_illegal(input logic [3:0] c);
        return (c >= 4'h4) && (c <= 4'hE);
    endfunction

    function automatic logic [19:0] rand_word();
        logic [3:0] c;
        int r = $urandom_range(0, 8);
        if (r == 8) c = 4'($urandom_range(4, 14));
        else        c = 4'(r / 2);
        return {c, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
    endfunction

    task automatic apply_reset();
        run = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_data = '0;
        bus.fsm_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.fsm_start != 4'h0) seen = 1'b1;
        end
    endtask

    // Memory + execution-FSM model with a cycle-level scoreboard of the dispatch rules.
    task automatic run_prog(input int n_instr, input bit drop_run, input int max_lat);
        int cyc = 0, retired = 0, tail = 0, lat = -1, done_lat = -1;
        int v_cyc = -100, adv_cyc = -100, halt_cyc = -1;
        bit prev_req = 1'b0, in_exec = 1'b0, go_idle = 1'b0;
        logic [19:0] w = '0;
        logic [7:0] m_pc = 8'd0;
        logic [3:0] cls, exp_start;
        bit exp_ill;
        run = 1'b1;
        while (tail < 6 && cyc < 20000) begin
            @(posedge clk); #1; cyc++;
            bus.imem_valid = 1'b0;
            bus.fsm_done = 1'b0;
            if (bus.imem_req && !prev_req) begin
                n_tests++;
                if (bus.imem_addr !== m_pc || go_idle || halt_cyc >= 0 ||
                    (adv_cyc >= 0 && cyc != adv_cyc + 1)) begin
                    n_fail++;
                    $display("FAIL fetch_start cyc=%0d addr=%0h exp_addr=%0h exp_cyc=%0d idle=%0b halt=%0d",
                             cyc, bus.imem_addr, m_pc, adv_cyc + 1, go_idle, halt_cyc);
                end
                lat = $urandom_range(0, max_lat);
            end
            if (bus.imem_req) begin
                if (lat == 0) begin
                    w = mem[bus.imem_addr];
                    bus.imem_valid = 1'b1;
                    bus.imem_data = w;
                    v_cyc = cyc;
                    lat = -1;
                end else if (lat > 0) begin
                    lat--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_data = 20'($urandom);
            end
            cls = w[19:16];
            exp_start = (is_exec(cls) && cyc == v_cyc + 2) ? cls : 4'h0;
            exp_ill = is_illegal(cls) && (cyc == v_cyc + 2);
            n_tests++;
            if (bus.fsm_start !== exp_start) begin
                n_fail++;
                $display("FAIL fsm_start cyc=%0d got=%0h exp=%0h", cyc, bus.fsm_start, exp_start);
            end
            n_tests++;
            if (illegal !== exp_ill) begin
                n_fail++;
                $display("FAIL illegal_instr cyc=%0d got=%0b exp=%0b", cyc, illegal, exp_ill);
            end
            n_tests++;
            if (tmo !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_err cyc=%0d got=%0b exp=0", cyc, tmo);
            end
            if (in_exec || exp_start != 4'h0) begin
                n_tests++;
                if ({bus.opcode, bus.param1, bus.param2} !== w[15:0]) begin
                    n_fail++;
                    $display("FAIL decode_fields cyc=%0d got=%0h exp=%0h", cyc,
                             {bus.opcode, bus.param1, bus.param2}, w[15:0]);
                end
            end
            if (cyc == v_cyc + 2) begin
                if (is_exec(cls)) begin
                    in_exec = 1'b1;
                    done_lat = $urandom_range(0, 4);
                    bus.fsm_done = 1'($urandom_range(0, 1));
                    if (drop_run) run = 1'b0;
                end else if (cls == 4'hF) begin
                    halt_cyc = cyc;
                    retired++;
                end else begin
                    adv_cyc = cyc;
                    m_pc = m_pc + 8'd1;
                    retired++;
                    go_idle = !run;
                end
            end else if (in_exec) begin
                if (done_lat == 0) begin
                    bus.fsm_done = 1'b1;
                    in_exec = 1'b0;
                    adv_cyc = cyc + 1;
                    m_pc = m_pc + 8'd1;
                    retired++;
                    go_idle = !run;
                end else begin
                    done_lat--;
                end
            end
            if (halt_cyc >= 0 && cyc >= halt_cyc) begin
                n_tests++;
                if (halted !== 1'b1 || busy !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== m_pc) begin
                    n_fail++;
                    $display("FAIL halt_state cyc=%0d halted=%0b busy=%0b req=%0b addr=%0h exp=1/0/0/%0h",
                             cyc, halted, busy, bus.imem_req, bus.imem_addr, m_pc);
                end
            end else begin
                n_tests++;
                if (halted !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halted_early cyc=%0d got=%0b exp=0", cyc, halted);
                end
            end
            if (go_idle && cyc >= adv_cyc + 1) begin
                n_tests++;
                if (busy !== 1'b0 || bus.imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_after_stop cyc=%0d busy=%0b req=%0b exp=0/0", cyc, busy, bus.imem_req);
                end
            end else if (bus.imem_req) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_in_fetch cyc=%0d got=%0b exp=1", cyc, busy);
                end
            end
            prev_req = bus.imem_req;
            if (retired >= n_instr) tail++;
        end
        bus.imem_valid = 1'b0;
        bus.fsm_done = 1'b0;
        if (cyc >= 20000) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_prog_budget retired=%0d exp=%0d", retired, n_instr);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({bus.imem_addr, bus.imem_req, bus.fsm_start, bus.opcode, bus.param1, bus.param2,
             busy, halted, illegal, tmo} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%0h exp=0", {bus.imem_addr, bus.imem_req, bus.fsm_start,
                     bus.opcode, bus.param1, bus.param2, busy, halted, illegal, tmo});
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (bus.imem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_without_run req=%0b busy=%0b exp=0/0", bus.imem_req, busy);
        end
    endtask

    task automatic test_alu_dispatch();
        mem[0] = 20'h23041;
        mem[1] = 20'h23041;
        apply_reset();
        run_prog(1, 1'b0, 0);
    endtask

    task automatic test_halt();
        mem[0] = 20'h0_0_000;
        mem[1] = 20'h7_5_123;
        mem[2] = 20'hF_0_000;
        apply_reset();
        run_prog(3, 1'b0, 2);
        n_tests++;
        if (halted !== 1'b1 || busy !== 1'b0 || bus.imem_addr !== 8'd2) begin
            n_fail++;
            $display("FAIL halt_final halted=%0b busy=%0b addr=%0h exp=1/0/2", halted, busy, bus.imem_addr);
        end
    endtask

    task automatic test_random_wrap();
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
        apply_reset();
        run_prog(300, 1'b0, 3);
    endtask

    task automatic test_run_drop();
        bit seen;
        mem[0] = {4'h1, 4'($urandom_range(0, 15)), 12'($urandom)};
        mem[1] = 20'h3_2_0C5;
        apply_reset();
        run_prog(1, 1'b1, 2);
        n_tests++;
        if (busy !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== 8'd1) begin
            n_fail++;
            $display("FAIL run_drop_final busy=%0b req=%0b addr=%0h exp=0/0/1", busy, bus.imem_req, bus.imem_addr);
        end
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus.imem_req;
        end
        n_tests++;
        if (!seen || bus.imem_addr !== 8'd1) begin
            n_fail++;
            $display("FAIL rerun_fetch seen=%0b addr=%0h exp=1/1", seen, bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        mem[0] = 20'h2_5_0C3;
        apply_reset();
        run = 1'b1;
        bus.imem_valid = 1'b1;
        bus.imem_data = mem[0];
        wait_start(20, seen);
        bus.imem_valid = 1'b0;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid_issue seen=0 exp=1");
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.imem_addr, bus.imem_req, bus.fsm_start, bus.opcode, bus.param1, bus.param2,
             busy, halted, illegal, tmo} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs got=%0h exp=0", {bus.imem_addr, bus.imem_req, bus.fsm_start,
                     bus.opcode, bus.param1, bus.param2, busy, halted, illegal, tmo});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus.imem_req;
        end
        n_tests++;
        if (!seen || bus.imem_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL refetch_after_reset seen=%0b addr=%0h exp=1/0", seen, bus.imem_addr);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        for (int rep = 0; rep < 2; rep++) begin
            mem[0] = 20'h2_1_000;
            mem[1] = 20'h0_0_000;
            apply_reset();
            run = 1'b1;
            bus.imem_valid = 1'b1;
            bus.imem_data = mem[0];
            wait_start(20, seen);
            bus.imem_valid = 1'b0;
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL timeout_issue seen=0 exp=1");
            end
`ifdef DISPATCH_TIMEOUT_EN
            for (int k = 1; k <= 64; k++) begin
                @(posedge clk); #1;
                bus.fsm_done = (rep == 1) && (k == 64);
                n_tests++;
                if (tmo !== 1'b0 || bus.imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_wait k=%0d tmo=%0b req=%0b exp=0/0", k, tmo, bus.imem_req);
                end
            end
            @(posedge clk); #1;
            bus.fsm_done = 1'b0;
            n_tests++;
            if (tmo !== (rep == 0)) begin
                n_fail++;
                $display("FAIL timeout_pulse rep=%0d got=%0b exp=%0b", rep, tmo, rep == 0);
            end
            @(posedge clk); #1;
            n_tests++;
            if (tmo !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd1) begin
                n_fail++;
                $display("FAIL timeout_advance rep=%0d tmo=%0b req=%0b addr=%0h exp=0/1/1",
                         rep, tmo, bus.imem_req, bus.imem_addr);
            end
`else
            repeat (100 + rep * 50) @(posedge clk);
            #1;
            n_tests++;
            if (tmo !== 1'b0 || bus.imem_req !== 1'b0 || busy !== 1'b1 || bus.fsm_start !== 4'h0) begin
                n_fail++;
                $display("FAIL wait_indefinite tmo=%0b req=%0b busy=%0b start=%0h exp=0/0/1/0",
                         tmo, bus.imem_req, busy, bus.fsm_start);
            end
            bus.fsm_done = 1'b1;
            @(posedge clk); #1;
            bus.fsm_done = 1'b0;
            @(posedge clk); #1;
            n_tests++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd1) begin
                n_fail++;
                $display("FAIL late_done_advance req=%0b addr=%0h exp=1/1", bus.imem_req, bus.imem_addr);
            end
`endif
        end
    endtask

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_data = '0;
        bus.fsm_done = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_alu_dispatch();
        test_halt();
        test_run_drop();
        test_reset_mid_wait();
        test_timeout();
        test_random_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
